gsr_run_controller: RTL and testbench
=====================================

Name: gsr_run_controller

Overview:
- Hardware replacement for the bench-driven multi-seed loop around the gSROr datapath.
- Sequences NUM_SEEDS independent simulation runs: fetches each seed from a seed memory, then pulses datapath init, inhibitor load and start in turn.
- Waits for each run to reach ITER_TARGET iterations.
- Accumulates, per rule, how many runs ended with that rule ON; software reads the counts after done.

Parameters:
RULES, 16, network width (rules/nodes)
LOG_RULES, 4, width of sel_inhibitor
LOG_ITER, 8, width of iteration_number
NUM_SEEDS, 64, runs per batch (>=1)
SEED_W, 64, seed width
ITER_TARGET, 200, iteration count that ends a run (< 2**LOG_ITER)
TIMEOUT_CYC, 4096, watchdog cycles per run in RUN state

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cmd_start  in  1  begin batch; sampled only in IDLE
cmd_abort  in  1  return to IDLE from any state next cycle; counters keep partial values
inhibitor  in  LOG_RULES  inhibitor index, latched on cmd_start
seed_addr  out  $clog2(NUM_SEEDS)  seed memory address
seed_rd  out  1  seed memory read strobe
seed_data  in  SEED_W  seed memory data, valid 1 cycle after seed_rd
dp_init  out  1  datapath init pulse
dp_ld_inhibitor  out  1  datapath inhibitor load pulse
dp_start  out  1  datapath start pulse
dp_seed  out  SEED_W  seed to datapath, held for the whole run
dp_sel_inhibitor  out  LOG_RULES  ~inhibitor, held for the whole batch
network_state  in  RULES  datapath state
steady_state  in  1  datapath steady flag
iteration_number  in  LOG_ITER  datapath iteration count
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse when batch completes
err_timeout  out  1  sticky; set on watchdog expiry, cleared on cmd_start
acc_sel  in  LOG_RULES  readout select
acc_count  out  $clog2(NUM_SEEDS+1)  combinational count for rule acc_sel; 0 if acc_sel >= RULES

Behaviour:
- Reset values:
  - Every output is 0, except dp_sel_inhibitor, which is all-ones (~0).
  - Counters, seed index and latches are cleared; state is IDLE.
- FSM states: IDLE, FETCH, LATCH, INIT, LDINH, START, RUN, ACCUM, DONE.
- IDLE:
  - On cmd_start: latch inhibitor, clear counters and err_timeout, set idx=0, go to FETCH.
  - cmd_start outside IDLE is ignored.
- FETCH: seed_rd=1, seed_addr=idx; go to LATCH.
- LATCH: dp_seed <= seed_data; go to INIT.
- INIT: dp_init=1 for 1 cycle. LDINH: dp_ld_inhibitor=1 for 1 cycle. START: dp_start=1 for 1 cycle; clear the watchdog. Each of these advances to the next state after its one cycle.
- RUN:
  - Exit to ACCUM when iteration_number >= ITER_TARGET.
  - Also exit to ACCUM when the watchdog reaches TIMEOUT_CYC; this sets err_timeout.
- ACCUM:
  - For each rule r, counter[r] += network_state[r].
  - If idx == NUM_SEEDS-1, go to DONE; else idx++ and go to FETCH.
- DONE: done=1 for 1 cycle; go to IDLE.
- Latency per run: 6 fixed cycles plus the RUN duration.
- Counter width $clog2(NUM_SEEDS+1) guarantees no overflow; all-ON over all runs yields exactly NUM_SEEDS.
- cmd_abort has priority over every transition, including done.
- Reset mid-run returns to IDLE immediately with all counters cleared.
- NUM_SEEDS=1: ACCUM goes straight to DONE; seed_addr is width 1 and always 0.

Optional Feature:
- Macro: GSR_EARLY_STOP_EN.
- Defined:
  - RUN also exits when steady_state is high for 2 consecutive cycles after START.
  - An early-stop counter (same width as acc_count) increments per early-stopped run, readable when acc_sel == all-ones.
- Undefined: steady_state is ignored, and acc_sel == all-ones reads 0 unless RULES covers that index.

Decomposition:
- Package gsr_pkg holds:
  - the state enum type;
  - the width localparams for counter and address widths (computed via $clog2);
  - the default ITER_TARGET/TIMEOUT constants.
- Sub-module gsr_rule_accum contains:
  - the RULES counter array with synchronous clear and an add-enable;
  - readout by select (acc_sel → acc_count).

Test Plan:
- NUM_SEEDS=4, datapath model holding network_state=16'h00FF at ITER_TARGET → done after 4 runs; acc_count is 4 for rules 0-7 and 0 for rules 8-15; seed_addr sequence 0,1,2,3.
- inhibitor=3 → dp_sel_inhibitor=~4'd3=4'hC throughout the batch; dp_init, dp_ld_inhibitor, dp_start each 1 cycle high, on consecutive cycles, once per run.
- iteration_number frozen at 10 with TIMEOUT_CYC=50 → ACCUM entered 50 cycles after START, err_timeout=1; batch still completes.
- cmd_abort asserted in RUN of run 2 → IDLE next cycle, busy=0, no done pulse, counts reflect runs 0-1 only.
- rst asserted asynchronously mid-FETCH → all outputs at reset values before the next clk edge; a subsequent cmd_start runs the full batch correctly.
- GSR_EARLY_STOP_EN: steady_state high at iteration 5 for 2 cycles → run ends before ITER_TARGET; early-stop count reads 1 via acc_sel=all-ones.

Source files
------------

// File: rtl/gsr_pkg.sv
// Shared types, default parameters and width helpers for the gSROr run controller.
// Optional build macro GSR_EARLY_STOP_EN is consumed by gsr_run_controller.
package gsr_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_INIT,
    S_LDINH,
    S_START,
    S_RUN,
    S_ACCUM,
    S_DONE
  } gsr_state_e;

  localparam int unsigned RULES_DEF       = 16;
  localparam int unsigned LOG_RULES_DEF   = 4;
  localparam int unsigned LOG_ITER_DEF    = 8;
  localparam int unsigned NUM_SEEDS_DEF   = 64;
  localparam int unsigned SEED_W_DEF      = 64;
  localparam int unsigned ITER_TARGET_DEF = 200;
  localparam int unsigned TIMEOUT_CYC_DEF = 4096;

  // A single-seed batch still needs a 1-bit address.
  function automatic int unsigned addr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Wide enough to hold n itself (all runs ON).
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  localparam int unsigned ADDR_W_DEF = addr_w(NUM_SEEDS_DEF);
  localparam int unsigned CNT_W_DEF  = cnt_w(NUM_SEEDS_DEF);

endpackage

// File: rtl/gsr_run_controller_if.sv
// Command, seed-memory, datapath and readout signals of the run controller.
// master = controller side, slave = host / memory / datapath side.
interface gsr_run_controller_if
  import gsr_pkg::*;
#(
  parameter int unsigned RULES     = RULES_DEF,
  parameter int unsigned LOG_RULES = LOG_RULES_DEF,
  parameter int unsigned LOG_ITER  = LOG_ITER_DEF,
  parameter int unsigned SEED_W    = SEED_W_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) ();

  logic                 cmd_start;
  logic                 cmd_abort;
  logic [LOG_RULES-1:0] inhibitor;
  logic [ADDR_W-1:0]    seed_addr;
  logic                 seed_rd;
  logic [SEED_W-1:0]    seed_data;
  logic                 dp_init;
  logic                 dp_ld_inhibitor;
  logic                 dp_start;
  logic [SEED_W-1:0]    dp_seed;
  logic [LOG_RULES-1:0] dp_sel_inhibitor;
  logic [RULES-1:0]     network_state;
  logic                 steady_state;
  logic [LOG_ITER-1:0]  iteration_number;
  logic                 busy;
  logic                 done;
  logic                 err_timeout;
  logic [LOG_RULES-1:0] acc_sel;
  logic [CNT_W-1:0]     acc_count;

  modport master (
    input  cmd_start, cmd_abort, inhibitor, seed_data, network_state,
           steady_state, iteration_number, acc_sel,
    output seed_addr, seed_rd, dp_init, dp_ld_inhibitor, dp_start, dp_seed,
           dp_sel_inhibitor, busy, done, err_timeout, acc_count
  );

  modport slave (
    output cmd_start, cmd_abort, inhibitor, seed_data, network_state,
           steady_state, iteration_number, acc_sel,
    input  seed_addr, seed_rd, dp_init, dp_ld_inhibitor, dp_start, dp_seed,
           dp_sel_inhibitor, busy, done, err_timeout, acc_count
  );

endinterface

// File: rtl/gsr_rule_accum.sv
// Per-rule ON counters for a batch, with synchronous clear, add-enable and select readout.
module gsr_rule_accum #(
  parameter int unsigned RULES     = 16,
  parameter int unsigned LOG_RULES = 4,
  parameter int unsigned CNT_W     = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 add_en,
  input  logic [RULES-1:0]     state_bits,
  input  logic [LOG_RULES-1:0] sel,
  output logic [CNT_W-1:0]     count
);

  logic [CNT_W-1:0] cnt_q [RULES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < RULES; r++) cnt_q[r] <= '0;
    end else if (clr) begin
      for (int r = 0; r < RULES; r++) cnt_q[r] <= '0;
    end else if (add_en) begin
      for (int r = 0; r < RULES; r++) cnt_q[r] <= cnt_q[r] + CNT_W'(state_bits[r]);
    end
  end

  // Selects past the last rule read as zero.
  always_comb begin
    count = '0;
    if (32'(sel) < RULES) count = cnt_q[sel];
  end

endmodule

// File: rtl/gsr_run_controller.sv
// Sequences NUM_SEEDS gSROr runs (fetch seed, init, load inhibitor, start, wait, accumulate).
// Optional macro GSR_EARLY_STOP_EN: end a run on 2 consecutive steady cycles and count such runs.
module gsr_run_controller
  import gsr_pkg::*;
#(
  parameter int unsigned RULES       = RULES_DEF,
  parameter int unsigned LOG_RULES   = LOG_RULES_DEF,
  parameter int unsigned LOG_ITER    = LOG_ITER_DEF,
  parameter int unsigned NUM_SEEDS   = NUM_SEEDS_DEF,
  parameter int unsigned SEED_W      = SEED_W_DEF,
  parameter int unsigned ITER_TARGET = ITER_TARGET_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input logic                  clk,
  input logic                  rst,
  gsr_run_controller_if.master bus
);

  localparam int unsigned ADDR_W = addr_w(NUM_SEEDS);
  localparam int unsigned CNT_W  = cnt_w(NUM_SEEDS);
  localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYC + 1);

  gsr_state_e           state_q, state_n;
  logic [ADDR_W-1:0]    idx_q, idx_n, seed_addr_q;
  logic [WDOG_W-1:0]    wdog_q, wdog_n;
  logic [SEED_W-1:0]    seed_q, seed_n;
  logic [LOG_RULES-1:0] sel_q, sel_n;
  logic                 err_q, err_n;
  logic                 seed_rd_q, init_q, ld_q, start_q, busy_q, done_q;
  logic                 clr_c, add_c;
  logic [CNT_W-1:0]     rule_count;
`ifdef GSR_EARLY_STOP_EN
  logic                 steady_q, steady_n, early_c;
  logic [CNT_W-1:0]     early_q;
`endif

  // Watchdog counts cycles since START, so RUN exits with the START-relative count at TIMEOUT_CYC.
  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    wdog_n  = wdog_q;
    seed_n  = seed_q;
    sel_n   = sel_q;
    err_n   = err_q;
    clr_c   = 1'b0;
    add_c   = 1'b0;
`ifdef GSR_EARLY_STOP_EN
    steady_n = steady_q;
    early_c  = 1'b0;
`endif
    if (bus.cmd_abort) begin
      state_n = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.cmd_start) begin
            sel_n   = ~bus.inhibitor;
            err_n   = 1'b0;
            idx_n   = '0;
            clr_c   = 1'b1;
            state_n = S_FETCH;
          end
        end
        S_FETCH: state_n = S_LATCH;
        S_LATCH: begin
          seed_n  = bus.seed_data;
          state_n = S_INIT;
        end
        S_INIT:  state_n = S_LDINH;
        S_LDINH: state_n = S_START;
        S_START: begin
          wdog_n  = WDOG_W'(1);
`ifdef GSR_EARLY_STOP_EN
          steady_n = 1'b0;
`endif
          state_n = S_RUN;
        end
        S_RUN: begin
          wdog_n = wdog_q + WDOG_W'(1);
`ifdef GSR_EARLY_STOP_EN
          steady_n = bus.steady_state;
`endif
          if (bus.iteration_number >= LOG_ITER'(ITER_TARGET)) begin
            state_n = S_ACCUM;
`ifdef GSR_EARLY_STOP_EN
          end else if (bus.steady_state && steady_q) begin
            state_n = S_ACCUM;
            early_c = 1'b1;
`endif
          end else if (wdog_q >= WDOG_W'(TIMEOUT_CYC - 1)) begin
            state_n = S_ACCUM;
            err_n   = 1'b1;
          end
        end
        S_ACCUM: begin
          add_c = 1'b1;
          if (idx_q == ADDR_W'(NUM_SEEDS - 1)) begin
            state_n = S_DONE;
          end else begin
            idx_n   = idx_q + ADDR_W'(1);
            state_n = S_FETCH;
          end
        end
        S_DONE:  state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Strobes are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      wdog_q      <= '0;
      seed_q      <= '0;
      sel_q       <= '1;
      err_q       <= 1'b0;
      seed_addr_q <= '0;
      seed_rd_q   <= 1'b0;
      init_q      <= 1'b0;
      ld_q        <= 1'b0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_n;
      idx_q       <= idx_n;
      wdog_q      <= wdog_n;
      seed_q      <= seed_n;
      sel_q       <= sel_n;
      err_q       <= err_n;
      seed_addr_q <= idx_n;
      seed_rd_q   <= (state_n == S_FETCH);
      init_q      <= (state_n == S_INIT);
      ld_q        <= (state_n == S_LDINH);
      start_q     <= (state_n == S_START);
      busy_q      <= (state_n != S_IDLE);
      done_q      <= (state_n == S_DONE);
    end
  end

`ifdef GSR_EARLY_STOP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      steady_q <= 1'b0;
      early_q  <= '0;
    end else begin
      steady_q <= steady_n;
      if (clr_c) early_q <= '0;
      else if (early_c) early_q <= early_q + CNT_W'(1);
    end
  end
`endif

  gsr_rule_accum #(
    .RULES     (RULES),
    .LOG_RULES (LOG_RULES),
    .CNT_W     (CNT_W)
  ) u_accum (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr_c),
    .add_en     (add_c),
    .state_bits (bus.network_state),
    .sel        (bus.acc_sel),
    .count      (rule_count)
  );

  assign bus.seed_addr        = seed_addr_q;
  assign bus.seed_rd          = seed_rd_q;
  assign bus.dp_init          = init_q;
  assign bus.dp_ld_inhibitor  = ld_q;
  assign bus.dp_start         = start_q;
  assign bus.dp_seed          = seed_q;
  assign bus.dp_sel_inhibitor = sel_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.err_timeout      = err_q;
`ifdef GSR_EARLY_STOP_EN
  assign bus.acc_count = (bus.acc_sel == '1) ? early_q : rule_count;
`else
  assign bus.acc_count = rule_count;
`endif

endmodule

// File: tb/tb_gsr_run_controller.sv
// Scoreboard bench for gsr_run_controller with seed-memory and datapath models.
module tb_gsr_run_controller;

  localparam int unsigned NS = 4;
  localparam int unsigned IT = 20;
  localparam int unsigned TO = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gsr_run_controller_if #(
    .RULES(16), .LOG_RULES(4), .LOG_ITER(8), .SEED_W(64), .ADDR_W(2), .CNT_W(3)
  ) bus ();

  gsr_run_controller #(
    .RULES(16), .LOG_RULES(4), .LOG_ITER(8), .NUM_SEEDS(NS), .SEED_W(64),
    .ITER_TARGET(IT), .TIMEOUT_CYC(TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] mem [NS];
  logic [7:0]  iter;
  logic        freeze    = 1'b0;
  logic        ns_const  = 1'b1;
  logic        steady_en = 1'b0;

  logic [1:0]  q_addr [$];
  logic [63:0] q_seed [$];
  logic [3:0]  exp_sel   = 4'hF;
  int          exp_gap   = IT + 3;
  int          gap_run0  = IT + 3;
  int          exp_early = 0;
  int          cyc = 0, t_start = 0;
  bit          t_valid = 1'b0;
  int          n_init = 0, n_ld = 0, n_start = 0, n_done = 0;
  logic        prev_init = 1'b0, prev_ld = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp_v);
    n_tests++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp_v);
    end
  endtask

  // Seed memory: registered read, data valid the cycle after seed_rd.
  always @(posedge clk) if (bus.seed_rd) bus.seed_data <= mem[bus.seed_addr];

  // Datapath: iteration restarts at dp_start and counts up (or sticks at 10 when frozen).
  always @(posedge clk or posedge rst) begin
    if (rst)               iter <= 8'd0;
    else if (freeze)       iter <= 8'd10;
    else if (bus.dp_start) iter <= 8'd0;
    else if (iter != 8'hFF) iter <= iter + 8'd1;
  end
  assign bus.iteration_number = iter;
  assign bus.network_state    = ns_const ? 16'h00FF : bus.dp_seed[15:0];
  assign bus.steady_state     = steady_en && (iter == 8'd5 || iter == 8'd6);

  // Output monitor / scoreboard consumer.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if ((bus.seed_rd || bus.done) && t_valid) begin
        check_val("run_len", 64'(cyc - t_start), 64'((n_start == 1) ? gap_run0 : exp_gap));
        t_valid = 1'b0;
      end
      if (bus.seed_rd) begin
        check_val("addr_q_nonempty", 64'(q_addr.size() != 0), 64'd1);
        if (q_addr.size() != 0) check_val("seed_addr", 64'(bus.seed_addr), 64'(q_addr.pop_front()));
      end
      if (bus.dp_init) begin
        n_init++;
        check_val("seed_q_nonempty", 64'(q_seed.size() != 0), 64'd1);
        if (q_seed.size() != 0) check_val("dp_seed", bus.dp_seed, q_seed.pop_front());
      end
      if (bus.dp_ld_inhibitor) begin
        n_ld++;
        check_val("ld_after_init", 64'(prev_init), 64'd1);
      end
      if (bus.dp_start) begin
        n_start++;
        check_val("start_after_ld", 64'(prev_ld), 64'd1);
        t_start = cyc;
        t_valid = 1'b1;
      end
      if (bus.done) n_done++;
      if (bus.busy) check_val("sel_inhibitor", 64'(bus.dp_sel_inhibitor), 64'(exp_sel));
    end
    prev_init = bus.dp_init;
    prev_ld   = bus.dp_ld_inhibitor;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic new_mem();
    for (int i = 0; i < NS; i++) mem[i] = {$urandom, $urandom};
  endtask

  task automatic start_batch(input logic [3:0] inh);
    tick(1);
    q_addr.delete();
    q_seed.delete();
    for (int i = 0; i < NS; i++) begin
      q_addr.push_back(2'(i));
      q_seed.push_back(mem[i]);
    end
    n_init = 0; n_ld = 0; n_start = 0; n_done = 0;
    t_valid = 1'b0;
    exp_sel = ~inh;
    bus.inhibitor = inh;
    bus.cmd_start = 1'b1;
    tick(1);
    bus.cmd_start = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (n_done == 0 && k < 3000) begin tick(1); k++; end
    tick(3);
    check_val("done_pulses", 64'(n_done), 64'd1);
    check_val("busy_after_done", 64'(bus.busy), 64'd0);
    check_val("init_pulses", 64'(n_init), 64'(NS));
    check_val("ld_pulses", 64'(n_ld), 64'(NS));
    check_val("start_pulses", 64'(n_start), 64'(NS));
  endtask

  task automatic check_counts(input int runs);
    int          exp_c [16];
    int          ev;
    logic [15:0] pat;
    for (int r = 0; r < 16; r++) exp_c[r] = 0;
    for (int i = 0; i < runs; i++) begin
      pat = ns_const ? 16'h00FF : mem[i][15:0];
      for (int r = 0; r < 16; r++) exp_c[r] += int'(pat[r]);
    end
    for (int r = 0; r < 16; r++) begin
      bus.acc_sel = 4'(r);
      #1;
      ev = exp_c[r];
`ifdef GSR_EARLY_STOP_EN
      if (r == 15) ev = exp_early;
`endif
      check_val($sformatf("acc_count[%0d]", r), 64'(bus.acc_count), 64'(ev));
    end
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int k;
    bus.cmd_start = 1'b0;
    bus.cmd_abort = 1'b0;
    bus.inhibitor = 4'd0;
    bus.acc_sel   = 4'd0;
    new_mem();
    tick(3);

    check_val("rst_busy", 64'(bus.busy), 64'd0);
    check_val("rst_done", 64'(bus.done), 64'd0);
    check_val("rst_seed_rd", 64'(bus.seed_rd), 64'd0);
    check_val("rst_seed_addr", 64'(bus.seed_addr), 64'd0);
    check_val("rst_dp_init", 64'(bus.dp_init), 64'd0);
    check_val("rst_dp_ld", 64'(bus.dp_ld_inhibitor), 64'd0);
    check_val("rst_dp_start", 64'(bus.dp_start), 64'd0);
    check_val("rst_dp_seed", bus.dp_seed, 64'd0);
    check_val("rst_sel_inh", 64'(bus.dp_sel_inhibitor), 64'hF);
    check_val("rst_err", 64'(bus.err_timeout), 64'd0);
    check_val("rst_acc", 64'(bus.acc_count), 64'd0);
    rst = 1'b0;

    // Constant 0x00FF network, inhibitor 3.
    ns_const = 1'b1;
    start_batch(4'd3);
    wait_done();
    check_val("a_err", 64'(bus.err_timeout), 64'd0);
    check_counts(NS);

    // Seed-dependent network; a cmd_start mid-batch must be ignored.
    ns_const = 1'b0;
    new_mem();
    start_batch(4'd9);
    k = 0;
    while (n_start < 1 && k < 500) begin tick(1); k++; end
    bus.inhibitor = 4'd5;
    bus.cmd_start = 1'b1;
    tick(1);
    bus.cmd_start = 1'b0;
    wait_done();
    check_counts(NS);

    // Frozen iteration count: every run ends on the watchdog.
    freeze = 1'b1;
    exp_gap = TO + 1;
    gap_run0 = TO + 1;
    new_mem();
    start_batch(4'd0);
    wait_done();
    check_val("c_err", 64'(bus.err_timeout), 64'd1);
    check_counts(NS);
    freeze = 1'b0;
    exp_gap = IT + 3;
    gap_run0 = IT + 3;

    // Abort during run 2.
    new_mem();
    start_batch(4'd6);
    check_val("d_err_cleared", 64'(bus.err_timeout), 64'd0);
    k = 0;
    while (n_start < 3 && k < 1000) begin tick(1); k++; end
    check_val("d_reach_run2", 64'(n_start), 64'd3);
    tick(5);
    bus.cmd_abort = 1'b1;
    tick(1);
    bus.cmd_abort = 1'b0;
    check_val("d_busy", 64'(bus.busy), 64'd0);
    tick(40);
    check_val("d_no_done", 64'(n_done), 64'd0);
    check_val("d_addr_left", 64'(q_addr.size()), 64'd1);
    check_counts(2);

    // Asynchronous reset in the FETCH of run 1.
    ns_const = 1'b1;
    new_mem();
    bus.acc_sel = 4'd0;
    start_batch(4'd3);
    k = 0;
    while (!(n_init >= 1 && bus.seed_rd) && k < 1000) begin tick(1); k++; end
    check_val("e_reach_fetch", 64'(bus.seed_rd), 64'd1);
    #2 rst = 1'b1;
    #1;
    check_val("e_busy", 64'(bus.busy), 64'd0);
    check_val("e_seed_rd", 64'(bus.seed_rd), 64'd0);
    check_val("e_seed_addr", 64'(bus.seed_addr), 64'd0);
    check_val("e_dp_seed", bus.dp_seed, 64'd0);
    check_val("e_sel_inh", 64'(bus.dp_sel_inhibitor), 64'hF);
    check_val("e_acc0", 64'(bus.acc_count), 64'd0);
    tick(1);
    rst = 1'b0;
    t_valid = 1'b0;

    // Full batch after the reset.
    ns_const = 1'b0;
    new_mem();
    start_batch(4'd12);
    wait_done();
    check_counts(NS);

`ifdef GSR_EARLY_STOP_EN
    // Steady for two cycles at iteration 5 in run 0 only.
    ns_const = 1'b1;
    new_mem();
    steady_en = 1'b1;
    gap_run0 = 9;
    exp_early = 1;
    start_batch(4'd1);
    k = 0;
    while (n_start < 1 && k < 500) begin tick(1); k++; end
    tick(10);
    steady_en = 1'b0;
    wait_done();
    check_counts(NS);
    gap_run0 = exp_gap;
    exp_early = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
